// File: rtl/subbytes_lanes.sv
// rtl/subbytes_lanes.sv - multi-lane AES SubBytes/InvSubBytes engine with capture buffer and abort

// GF(2^8) multiplicative inverse (AES polynomial 0x11b), 0 maps to 0
module gf_inv8 (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) begin
                p = p ^ t;
            end
            t = xtime(t);
        end
        return p;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128, built by repeated squaring
    always_comb begin
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        y = (a == 8'h00) ? 8'h00 : acc;
    end
endmodule

// Forward S-box: field inverse followed by the affine transform
module sbox (
    input  logic [7:0] in,
    output logic [7:0] out
);
    logic [7:0] inv_b;

    gf_inv8 u_inv (
        .a (in),
        .y (inv_b)
    );

    assign out = inv_b
               ^ {inv_b[6:0], inv_b[7]}
               ^ {inv_b[5:0], inv_b[7:6]}
               ^ {inv_b[4:0], inv_b[7:5]}
               ^ {inv_b[3:0], inv_b[7:4]}
               ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by the field inverse
module inv_sbox (
    input  logic [7:0] in,
    output logic [7:0] out
);
    logic [7:0] aff;

    assign aff = {in[6:0], in[7]}
               ^ {in[4:0], in[7:5]}
               ^ {in[1:0], in[7:2]}
               ^ 8'h05;

    gf_inv8 u_inv (
        .a (aff),
        .y (out)
    );
endmodule

module subbytes_lanes #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         inv,
    input  logic [127:0] state_in,
    input  logic         abort,
    output logic [127:0] state_out,
    output logic         busy,
    output logic         done
);
    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("subbytes_lanes: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  k_q, k_d;
    logic [127:0]   buf_q, buf_d;
    logic [127:0]   out_q, out_d;
    logic           inv_q, inv_d;
    logic           done_q, done_d;

    logic [3:0]     byte_base;
    logic           last_beat;
    logic [7:0]     lane_in  [LANES];
    logic [7:0]     lane_fwd [LANES];
    logic [7:0]     lane_rev [LANES];
    logic [7:0]     lane_out [LANES];

    // first byte handled in the current beat; wraps harmlessly to 0 when LANES=16
    assign byte_base = 4'(int'(k_q) * LANES);
    assign last_beat = (k_q == CW'(BEATS - 1));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_in[i] = buf_q[{byte_base + 4'(i), 3'b000} +: 8];

        sbox u_sbox (
            .in  (lane_in[i]),
            .out (lane_fwd[i])
        );

        inv_sbox u_inv_sbox (
            .in  (lane_in[i]),
            .out (lane_rev[i])
        );

        assign lane_out[i] = inv_q ? lane_rev[i] : lane_fwd[i];
    end

    // next-state: capture on start, write one beat per cycle, abort wins over completion
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        buf_d   = buf_q;
        inv_d   = inv_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    buf_d   = state_in;
                    inv_d   = inv;
                    out_d   = '0;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    out_d   = '0;
                    k_d     = '0;
                    state_d = ST_IDLE;
                end else begin
                    for (int i = 0; i < LANES; i++) begin
                        out_d[{byte_base + 4'(i), 3'b000} +: 8] = lane_out[i];
                    end
                    if (last_beat) begin
                        done_d  = 1'b1;
                        k_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            buf_q   <= '0;
            out_q   <= '0;
            inv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
        end
    end

    assign state_out = out_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
endmodule

// File: tb/tb_subbytes_lanes.sv
// tb/tb_subbytes_lanes.sv - directed bench for subbytes_lanes at LANES = 1, 2, 4, 8, 16
module tb_subbytes_lanes;
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic         clk;
    logic         rst_n;
    logic [4:0]   start_v;
    logic         inv;
    logic [127:0] state_in;
    logic         abort;
    logic [127:0] out_v [5];
    logic [4:0]   busy_v;
    logic [4:0]   done_v;

    int n_cmp;
    int n_fail;

    // instance g runs with LANES = 2**g
    for (genvar gi = 0; gi < 5; gi++) begin : g_dut
        subbytes_lanes #(
            .LANES (1 << gi)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_v[gi]),
            .inv       (inv),
            .state_in  (state_in),
            .abort     (abort),
            .state_out (out_v[gi]),
            .busy      (busy_v[gi]),
            .done      (done_v[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // start pulse on instance g; returns at the first negedge after the start edge,
    // with inputs scrambled to show they are not re-sampled
    task automatic launch(input int g, input logic [127:0] d, input logic iv);
        @(negedge clk);
        state_in   = d;
        inv        = iv;
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        state_in   = ~d;
        inv        = ~iv;
    endtask

    // latency in edges after the start edge (-1 on timeout), done pulses seen, busy cycles seen
    task automatic wait_done(input int g, output int lat, output int nd, output int bc);
        int c;
        lat = -1;
        nd  = 0;
        bc  = 0;
        c   = 1;
        while (c <= 40 && lat < 0) begin
            if (done_v[g]) begin
                lat = c - 1;
            end else begin
                if (busy_v[g]) bc++;
                @(negedge clk);
                c++;
            end
        end
        if (lat >= 0) begin
            nd = 1;
            repeat (4) begin
                @(negedge clk);
                if (done_v[g]) nd++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            n_cmp++;
            if (out_v[g] !== 128'h0) begin
                n_fail++;
                $display("FAIL reset_out[%0d]: got %h expected 0", g, out_v[g]);
            end
            n_cmp++;
            if (busy_v[g] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy[%0d]: got %b expected 0", g, busy_v[g]);
            end
            n_cmp++;
            if (done_v[g] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_done[%0d]: got %b expected 0", g, done_v[g]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fwd_zero();
        int lat, nd, bc;
        launch(2, 128'h0, 1'b0);
        n_cmp++;
        if (busy_v[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_busy_after_start: got %b expected 1", busy_v[2]);
        end
        wait_done(2, lat, nd, bc);
        n_cmp++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d expected 4", lat);
        end
        n_cmp++;
        if (bc !== 4) begin
            n_fail++;
            $display("FAIL zero_busy_cycles: got %0d expected 4", bc);
        end
        n_cmp++;
        if (nd !== 1) begin
            n_fail++;
            $display("FAIL zero_done_count: got %0d expected 1", nd);
        end
        n_cmp++;
        if (out_v[2] !== {16{8'h63}}) begin
            n_fail++;
            $display("FAIL zero_result: got %h expected %h", out_v[2], {16{8'h63}});
        end
    endtask

    task automatic test_fwd_lanes1();
        int lat, nd, bc;
        launch(0, FIPS_IN, 1'b0);
        wait_done(0, lat, nd, bc);
        n_cmp++;
        if (lat !== 16) begin
            n_fail++;
            $display("FAIL l1_latency: got %0d expected 16", lat);
        end
        n_cmp++;
        if (nd !== 1) begin
            n_fail++;
            $display("FAIL l1_done_count: got %0d expected 1", nd);
        end
        n_cmp++;
        if (out_v[0] !== FIPS_OUT) begin
            n_fail++;
            $display("FAIL l1_result: got %h expected %h", out_v[0], FIPS_OUT);
        end
    endtask

    task automatic test_inv_lanes();
        int lat, nd, bc;
        int gs [3] = '{1, 3, 4};
        for (int n = 0; n < 3; n++) begin
            launch(gs[n], FIPS_OUT, 1'b1);
            wait_done(gs[n], lat, nd, bc);
            n_cmp++;
            if (lat !== (16 >> gs[n])) begin
                n_fail++;
                $display("FAIL inv_latency[%0d]: got %0d expected %0d", gs[n], lat, 16 >> gs[n]);
            end
            n_cmp++;
            if (nd !== 1) begin
                n_fail++;
                $display("FAIL inv_done_count[%0d]: got %0d expected 1", gs[n], nd);
            end
            n_cmp++;
            if (out_v[gs[n]] !== FIPS_IN) begin
                n_fail++;
                $display("FAIL inv_result[%0d]: got %h expected %h", gs[n], out_v[gs[n]], FIPS_IN);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int lat, nd, bc;
        launch(2, FIPS_IN, 1'b0);
        state_in   = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
        inv        = 1'b1;
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        wait_done(2, lat, nd, bc);
        n_cmp++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL restart_latency: got %0d expected 3", lat);
        end
        n_cmp++;
        if (nd !== 1) begin
            n_fail++;
            $display("FAIL restart_done_count: got %0d expected 1", nd);
        end
        n_cmp++;
        if (out_v[2] !== FIPS_OUT) begin
            n_fail++;
            $display("FAIL restart_result: got %h expected %h", out_v[2], FIPS_OUT);
        end
    endtask

    task automatic test_abort();
        int nd;
        launch(2, FIPS_IN, 1'b0);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (busy_v[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort2_busy: got %b expected 0", busy_v[2]);
        end
        n_cmp++;
        if (out_v[2] !== 128'h0) begin
            n_fail++;
            $display("FAIL abort2_out: got %h expected 0", out_v[2]);
        end
        nd = 0;
        if (done_v[2]) nd++;
        repeat (6) begin
            @(negedge clk);
            if (done_v[2]) nd++;
        end
        n_cmp++;
        if (nd !== 0) begin
            n_fail++;
            $display("FAIL abort2_done_count: got %0d expected 0", nd);
        end

        launch(2, FIPS_IN, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy_v[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_last_busy_before: got %b expected 1", busy_v[2]);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (busy_v[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_last_busy: got %b expected 0", busy_v[2]);
        end
        n_cmp++;
        if (out_v[2] !== 128'h0) begin
            n_fail++;
            $display("FAIL abort_last_out: got %h expected 0", out_v[2]);
        end
        nd = 0;
        if (done_v[2]) nd++;
        repeat (4) begin
            @(negedge clk);
            if (done_v[2]) nd++;
        end
        n_cmp++;
        if (nd !== 0) begin
            n_fail++;
            $display("FAIL abort_last_done_count: got %0d expected 0", nd);
        end
    endtask

    task automatic test_idle_abort_start();
        int lat, nd, bc;
        @(negedge clk);
        state_in   = 128'h0;
        inv        = 1'b0;
        start_v[2] = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        abort      = 1'b0;
        n_cmp++;
        if (busy_v[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL start_with_abort_busy: got %b expected 1", busy_v[2]);
        end
        wait_done(2, lat, nd, bc);
        n_cmp++;
        if (out_v[2] !== {16{8'h63}}) begin
            n_fail++;
            $display("FAIL start_with_abort_result: got %h expected %h", out_v[2], {16{8'h63}});
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_v[2] !== {16{8'h63}}) begin
            n_fail++;
            $display("FAIL idle_abort_hold: got %h expected %h", out_v[2], {16{8'h63}});
        end
        n_cmp++;
        if (busy_v[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_abort_busy: got %b expected 0", busy_v[2]);
        end
    endtask

    task automatic test_back_to_back();
        launch(4, FIPS_IN, 1'b0);
        n_cmp++;
        if (busy_v[4] !== 1'b1 || done_v[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first_run: got busy=%b done=%b expected busy=1 done=0", busy_v[4], done_v[4]);
        end
        @(negedge clk);
        n_cmp++;
        if (done_v[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_done: got %b expected 1", done_v[4]);
        end
        n_cmp++;
        if (out_v[4] !== FIPS_OUT) begin
            n_fail++;
            $display("FAIL b2b_first_result: got %h expected %h", out_v[4], FIPS_OUT);
        end
        state_in   = FIPS_OUT;
        inv        = 1'b1;
        start_v[4] = 1'b1;
        @(negedge clk);
        start_v[4] = 1'b0;
        state_in   = 128'h0;
        n_cmp++;
        if (busy_v[4] !== 1'b1 || done_v[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_run: got busy=%b done=%b expected busy=1 done=0", busy_v[4], done_v[4]);
        end
        @(negedge clk);
        n_cmp++;
        if (done_v[4] !== 1'b1 || busy_v[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_done: got done=%b busy=%b expected done=1 busy=0", done_v[4], busy_v[4]);
        end
        n_cmp++;
        if (out_v[4] !== FIPS_IN) begin
            n_fail++;
            $display("FAIL b2b_second_result: got %h expected %h", out_v[4], FIPS_IN);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nd, bc;
        logic [127:0] d;
        logic [127:0] e;
        d = 128'h0000ff53;
        e = {{14{8'h63}}, 8'h16, 8'hed};
        launch(2, d, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_v[2] !== 128'h0 || busy_v[2] !== 1'b0 || done_v[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got out=%h busy=%b done=%b expected all 0", out_v[2], busy_v[2], done_v[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch(2, d, 1'b0);
        wait_done(2, lat, nd, bc);
        n_cmp++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL post_reset_latency: got %0d expected 4", lat);
        end
        n_cmp++;
        if (out_v[2] !== e) begin
            n_fail++;
            $display("FAIL post_reset_result: got %h expected %h", out_v[2], e);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start_v  = 5'b0;
        inv      = 1'b0;
        state_in = 128'h0;
        abort    = 1'b0;
        test_reset();
        test_fwd_zero();
        test_fwd_lanes1();
        test_inv_lanes();
        test_restart_ignored();
        test_abort();
        test_idle_abort_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/subbytes_lanes.md
Name: subbytes_lanes

Overview:
Parametrised AES SubBytes / InvSubBytes engine. It processes the 128-bit state LANES bytes per cycle using LANES parallel S-box instances, so area can be traded against latency. Unlike the single-lane unit, it captures state_in internally on start (the caller need not hold it), supports both encrypt and decrypt direction, and supports a synchronous abort. It sits between the round controller and ShiftRows / InvShiftRows in the round datapath.

Parameters:
LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value must cause an elaboration error.
BEATS, 16/LANES, derived (localparam), number of processing cycles.

Ports:
clk  input  1  clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; accepted only when busy=0
inv  input  1  sampled with start; 0 = forward S-box, 1 = inverse S-box
state_in  input  128  state; byte j = state_in[8j+7:8j]; sampled only on an accepted start
abort  input  1  synchronous cancel of an operation in progress
state_out  output  128  result; byte j written by lane (j mod LANES) in beat j/LANES
busy  output  1  high from the edge after an accepted start until the edge of completion or abort
done  output  1  one-cycle pulse when state_out is complete

Behaviour:
- Reset (rst_n=0, asynchronous): state_out=0, busy=0, done=0, beat counter=0, capture buffer=0, inv register=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; counter k runs 0..BEATS-1.
- Submodules:
  - LANES instances of combinational sbox(in[7:0], out[7:0]).
  - LANES instances of inv_sbox with the same port order (separate module).
  - Per-lane 2:1 mux selected by the registered inv bit.
- Accepted start (edge E0, start=1 and busy=0):
  - state_in captured to buffer; inv captured; state_out cleared to 0; k=0; enter RUN.
- RUN, edge E0+k+1:
  - For each lane i, state_out byte (k*LANES+i) gets S(buffer byte (k*LANES+i)); k increments.
  - On the edge where k=BEATS-1: done=1 for exactly one cycle, return to IDLE.
- Latency: done is high in the cycle following edge E0+BEATS. The first result byte is visible after edge E0+1.
- state_out holds the final result until the next accepted start or reset. Intermediate (partially written) values are visible during RUN and carry no guarantee.
- start while busy=1: ignored; the buffer is not reloaded. start in the cycle done=1 is accepted (busy is already 0).
- abort=1 during RUN:
  - At the next edge: go to IDLE, busy=0, done stays 0, state_out cleared to 0.
  - abort has priority over the completion of the final beat.
- abort in IDLE: no effect. abort and start together in IDLE: start is accepted, abort is ignored.
- Reset mid-operation: immediate return to the reset values. No done is issued.
- Changing state_in or inv after the start edge has no effect on the result.
- LANES=16: BEATS=1, done at E0+1. The counter width is max(1, log2(BEATS)) bits; it returns to 0 when each operation completes.

Test Plan:
- LANES=4, inv=0, state_in all 0x00, start pulse → busy high for 4 cycles, done pulses once after edge E0+4, state_out = all 0x63.
- LANES=1, inv=0, state_in = 0x193de3bea0f4e22b9ac68d2ae9f84808 (FIPS-197 round 1) → state_out = 0xd42711aee0bf98f1b8b45de51e415230 after 16 beats.
- Same vector with inv=1 and state_in = 0xd42711aee0bf98f1b8b45de51e415230, repeated for LANES=2, 8 and 16 → state_out = 0x193de3bea0f4e22b9ac68d2ae9f84808; done latency 8 / 2 / 1 cycles respectively.
- LANES=4, corrupt state_in and pulse start again at beat 1 → second start ignored; result matches the first captured input; exactly one done pulse.
- abort at beat 2 → busy=0 at the next edge, no done pulse, state_out=0. Assert abort together with the final beat → no done.
- rst_n low mid-run at beat 1 → state_out=0, busy=0, done=0 immediately. A new start after release gives a correct result, e.g. bytes 0x53 → 0xED, 0xFF → 0x16.
